operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT_DONE cycles before abort (range 1..255).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-005 cmd_valid  input  1  command request from host.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_x  input  DATA_W  first operand.
REQ-008 cmd_y  input  DATA_W  second operand.
REQ-009 load  output  1  operand-load pulse to arithmetic unit.
REQ-010 data_out  output  DATA_W  operand bus to arithmetic unit.
REQ-011 start  output  1  operation-start pulse to arithmetic unit.
REQ-012 unit_ready  input  1  arithmetic unit result available.
REQ-013 unit_error  input  1  arithmetic unit rejected operands.
REQ-014 unit_result  input  2*DATA_W  arithmetic unit result.
REQ-015 rsp_valid  output  1  response available to host.
REQ-016 rsp_ready  input  1  host accepts response.
REQ-017 rsp_result  output  2*DATA_W  captured result.
REQ-018 rsp_status  output  2  00 OK, 01 ERROR, 10 TIMEOUT, 11 unused.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, DRIVE_X, GAP_X, DRIVE_Y, GAP_Y, START, WAIT_DONE, RESP.
REQ-021 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, capture cmd_x/cmd_y into internal registers, go to DRIVE_X.
REQ-022 cmd_ready SHALL be 0 in all states except IDLE; cmd_x/cmd_y changes after acceptance SHALL have no effect.
REQ-023 DRIVE_X: load=1, data_out=X, one cycle, then GAP_X.
REQ-024 GAP_X: load=0, data_out=X, one cycle, then DRIVE_Y.
REQ-025 DRIVE_Y: load=1, data_out=Y, one cycle, then GAP_Y.
REQ-026 GAP_Y: load=0, data_out=Y, one cycle, then START.
REQ-027 START: start=1, data_out=Y, one cycle, then WAIT_DONE with timeout counter cleared to 0.
REQ-028 load and start SHALL be exactly one-cycle pulses, never asserted together, and 0 outside DRIVE_X/DRIVE_Y/START.
REQ-029 data_out SHALL be 0 in IDLE, WAIT_DONE and RESP.
REQ-030 WAIT_DONE: counter increments by 1 each cycle without a unit response; 8-bit, no wrap (bounded by TIMEOUT).
REQ-031 WAIT_DONE: unit_error=1 -> status 01, rsp_result=0, go to RESP.
REQ-032 WAIT_DONE: unit_ready=1 and unit_error=0 -> capture unit_result, status 00, go to RESP.
REQ-033 unit_ready and unit_error high in the same cycle SHALL be treated as ERROR (error wins).
REQ-034 WAIT_DONE: counter reaching TIMEOUT with no response -> status 10, rsp_result=0, go to RESP; a response in that same cycle SHALL take priority over timeout.
REQ-035 unit_ready/unit_error SHALL be ignored outside WAIT_DONE.
REQ-036 RESP: rsp_valid=1, rsp_result/rsp_status held stable until rsp_valid&&rsp_ready, then IDLE.
REQ-037 Latency: cmd accept at edge N -> first load at cycle N+1, start at N+5; rsp_valid rises the cycle after the terminating WAIT_DONE cycle.
REQ-038 No new command SHALL be accepted in the cycle the response is consumed (cmd_ready rises the following cycle).

Reset
REQ-039 rst=1 at a rising edge SHALL force IDLE, clear X/Y registers, counter, rsp_result=0, rsp_status=00 from any state, including mid-transaction.
REQ-040 During and after reset: cmd_ready=1 (once rst=0), load=0, start=0, data_out=0, rsp_valid=0, busy=0.
REQ-041 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-042 OK path: cmd x=0x0003,y=0x0005; unit_ready with result 0x0000000F 3 cycles after start -> load pulses at N+1,N+3 with data 0x0003/0x0005, start at N+5, rsp status 00 result 0x0000000F.
REQ-043 Error: unit_error=1 1 cycle after start -> rsp_status 01, rsp_result 0; unit_ready+unit_error together -> 01.
REQ-044 Timeout: TIMEOUT=4, no unit response -> rsp_valid with status 10 after exactly 4 WAIT_DONE cycles.
REQ-045 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_result, rsp_status stable; cmd_valid ignored, cmd_ready=0.
REQ-046 Reset mid-op: rst=1 during GAP_Y -> next cycle IDLE, no start pulse issued, all outputs at reset values.
REQ-047 Back-to-back: two commands with rsp_ready=1 -> second accepted one cycle after first response consumed, operands not mixed.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand sequencer: feeds two captured operands to an arithmetic unit as
// load pulses, starts it, waits for a result/error/timeout and returns a response.
module operand_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_x,
  input  logic [DATA_W-1:0]   cmd_y,
  output logic                load,
  output logic [DATA_W-1:0]   data_out,
  output logic                start,
  input  logic                unit_ready,
  input  logic                unit_error,
  input  logic [2*DATA_W-1:0] unit_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [1:0]          rsp_status,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE_X, S_GAP_X, S_DRIVE_Y, S_GAP_Y, S_START, S_WAIT_DONE, S_RESP
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [7:0]        r_cnt;
  logic              w_accept;
  logic              w_timeout;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid && cmd_ready;
  // The last WAIT_DONE cycle is the one in which the count would reach TIMEOUT.
  assign w_timeout = (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_DRIVE_X;
      S_DRIVE_X:   w_next = S_GAP_X;
      S_GAP_X:     w_next = S_DRIVE_Y;
      S_DRIVE_Y:   w_next = S_GAP_Y;
      S_GAP_Y:     w_next = S_START;
      S_START:     w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (unit_ready || unit_error || w_timeout) w_next = S_RESP;
      S_RESP:      if (rsp_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      load       <= 1'b0;
      start      <= 1'b0;
      rsp_valid  <= 1'b0;
      data_out   <= '0;
      rsp_result <= '0;
      rsp_status <= 2'b00;
    end else begin
      r_state   <= w_next;
      cmd_ready <= (w_next == S_IDLE);
      busy      <= (w_next != S_IDLE);
      load      <= (w_next == S_DRIVE_X) || (w_next == S_DRIVE_Y);
      start     <= (w_next == S_START);
      rsp_valid <= (w_next == S_RESP);

      case (w_next)
        S_DRIVE_X:                  data_out <= cmd_x;
        S_GAP_X:                    data_out <= r_x;
        S_DRIVE_Y, S_GAP_Y, S_START: data_out <= r_y;
        default:                    data_out <= '0;
      endcase

      if (w_accept) begin
        r_x <= cmd_x;
        r_y <= cmd_y;
      end

      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT_DONE) && !unit_ready && !unit_error && !w_timeout) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (r_state == S_WAIT_DONE) begin
        if (unit_error) begin
          rsp_status <= 2'b01;
          rsp_result <= '0;
        end else if (unit_ready) begin
          rsp_status <= 2'b00;
          rsp_result <= unit_result;
        end else if (w_timeout) begin
          rsp_status <= 2'b10;
          rsp_result <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed vector table, reset corner cases and
// randomized transactions checked against a transaction-level timeline model.
module tb_operand_sequencer;

  localparam int DW = 16;
  localparam int TO = 4;
  localparam int K_READY = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [DW-1:0]   cmd_x;
  logic [DW-1:0]   cmd_y;
  logic            load;
  logic [DW-1:0]   data_out;
  logic            start;
  logic            unit_ready;
  logic            unit_error;
  logic [2*DW-1:0] unit_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*DW-1:0] rsp_result;
  logic [1:0]      rsp_status;
  logic            busy;

  operand_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .load(load), .data_out(data_out),
    .start(start), .unit_ready(unit_ready), .unit_error(unit_error),
    .unit_result(unit_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          kind;
    int          d;
    logic [31:0] res;
    int          bp;
    logic [1:0]  es;
    logic [31:0] er;
    int          ert;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response timeline from the rules: WAIT_DONE begins 6 cycles after accept;
  // a response at WAIT index d ends it unless d is past the timeout window.
  function automatic void model(input int kind, input int d, input logic [31:0] res,
                                output logic [1:0] st, output logic [31:0] r, output int rt);
    if (kind != K_NONE && d < TO) begin
      rt = 7 + d;
      if (kind == K_READY) begin st = 2'b00; r = res; end
      else begin st = 2'b01; r = '0; end
    end else begin
      rt = 7 + TO - 1;
      st = 2'b10;
      r  = '0;
    end
  endfunction

  task automatic run_txn(input int id, input logic [15:0] x, input logic [15:0] y,
                         input int kind, input int d, input logic [31:0] res, input int bp,
                         input logic [1:0] es, input logic [31:0] er, input int ert);
    logic [15:0] exp_d;
    check($sformatf("t%0d_idle_ready", id), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_x     = x;
    cmd_y     = y;
    step();
    for (int t = 1; t <= ert + bp; t++) begin
      exp_d = (t <= 2) ? x : (t <= 5) ? y : 16'h0;
      check($sformatf("t%0d_c%0d_load", id, t), load, (t == 1 || t == 3));
      check($sformatf("t%0d_c%0d_start", id, t), start, (t == 5));
      check($sformatf("t%0d_c%0d_data", id, t), data_out, exp_d);
      check($sformatf("t%0d_c%0d_busy", id, t), busy, 1);
      check($sformatf("t%0d_c%0d_cmdrdy", id, t), cmd_ready, 0);
      check($sformatf("t%0d_c%0d_rvalid", id, t), rsp_valid, (t >= ert));
      if (t >= ert) begin
        check($sformatf("t%0d_c%0d_status", id, t), rsp_status, es);
        check($sformatf("t%0d_c%0d_result", id, t), rsp_result, er);
      end
      if (t - 6 == d && kind != K_NONE) begin
        unit_ready  = (kind != K_ERR);
        unit_error  = (kind != K_READY);
        unit_result = res;
      end else if (t < 6 || t >= ert) begin
        unit_ready  = 1'($urandom);
        unit_error  = 1'($urandom);
        unit_result = $urandom;
      end else begin
        unit_ready  = 1'b0;
        unit_error  = 1'b0;
        unit_result = $urandom;
      end
      rsp_ready = (t >= ert + bp) ? 1'b1 : (t < ert) ? 1'($urandom) : 1'b0;
      cmd_valid = (t == ert + bp) ? 1'b1 : 1'($urandom);
      cmd_x     = 16'($urandom);
      cmd_y     = 16'($urandom);
      step();
    end
    check($sformatf("t%0d_post_busy", id), busy, 0);
    check($sformatf("t%0d_post_cmdrdy", id), cmd_ready, 1);
    check($sformatf("t%0d_post_rvalid", id), rsp_valid, 0);
    check($sformatf("t%0d_post_load", id), load, 0);
    cmd_valid  = 1'b0;
    unit_ready = 1'b0;
    unit_error = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic reset_at(input int id, input int at_t);
    cmd_valid = 1'b1;
    cmd_x     = 16'h1357;
    cmd_y     = 16'h2468;
    rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int t = 1; t <= at_t; t++) begin
      check($sformatf("r%0d_c%0d_start", id, t), start, (t == 5));
      unit_ready  = (t == 6);
      unit_error  = 1'b0;
      unit_result = 32'hDEADBEEF;
      if (t == at_t) begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
      end
      step();
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("r%0d_k%0d_cmdrdy", id, k), cmd_ready, 1);
      check($sformatf("r%0d_k%0d_busy", id, k), busy, 0);
      check($sformatf("r%0d_k%0d_load", id, k), load, 0);
      check($sformatf("r%0d_k%0d_start", id, k), start, 0);
      check($sformatf("r%0d_k%0d_data", id, k), data_out, 0);
      check($sformatf("r%0d_k%0d_rvalid", id, k), rsp_valid, 0);
      check($sformatf("r%0d_k%0d_result", id, k), rsp_result, 0);
      check($sformatf("r%0d_k%0d_status", id, k), rsp_status, 0);
      unit_ready = 1'b1;
      unit_error = 1'($urandom);
      step();
    end
    unit_ready = 1'b0;
    unit_error = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  st;
    logic [31:0] r;
    int          rt;
    int          kind;
    int          d;
    int          bp;
    logic [31:0] res;

    vt[0] = '{16'h0003, 16'h0005, K_READY, 2, 32'h0000000F, 0,  2'b00, 32'h0000000F, 9};
    vt[1] = '{16'h1234, 16'hABCD, K_ERR,   0, 32'h55555555, 0,  2'b01, 32'h0,        7};
    vt[2] = '{16'hFFFF, 16'h0001, K_BOTH,  1, 32'h00000077, 0,  2'b01, 32'h0,        8};
    vt[3] = '{16'h00AA, 16'h5500, K_NONE,  0, 32'h0,        0,  2'b10, 32'h0,        10};
    vt[4] = '{16'h8000, 16'h7FFF, K_READY, 3, 32'hFFFFFFFE, 0,  2'b00, 32'hFFFFFFFE, 10};
    vt[5] = '{16'h0F0F, 16'hF0F0, K_ERR,   3, 32'h00000001, 0,  2'b01, 32'h0,        10};
    vt[6] = '{16'hCAFE, 16'hBEEF, K_READY, 0, 32'h12345678, 10, 2'b00, 32'h12345678, 7};
    vt[7] = '{16'h0000, 16'h0000, K_READY, 4, 32'h00000099, 2,  2'b10, 32'h0,        10};

    rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0;
    unit_ready = 1'b0; unit_error = 1'b0; unit_result = '0; rsp_ready = 1'b0;
    step();
    step();
    check("rst_load", load, 0);
    check("rst_start", start, 0);
    check("rst_data", data_out, 0);
    check("rst_rvalid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    check("rst_cmdrdy", cmd_ready, 1);
    check("rst_status", rsp_status, 0);
    check("rst_result", rsp_result, 0);

    for (int i = 0; i < 8; i++)
      run_txn(i, vt[i].x, vt[i].y, vt[i].kind, vt[i].d, vt[i].res, vt[i].bp,
              vt[i].es, vt[i].er, vt[i].ert);

    reset_at(0, 4);
    reset_at(1, 8);
    run_txn(100, vt[0].x, vt[0].y, vt[0].kind, vt[0].d, vt[0].res, vt[0].bp,
            vt[0].es, vt[0].er, vt[0].ert);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      d    = $urandom_range(0, 5);
      bp   = $urandom_range(0, 3);
      res  = $urandom;
      model(kind, d, res, st, r, rt);
      run_txn(200 + i, 16'($urandom), 16'($urandom), kind, d, res, bp, st, r, rt);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check($sformatf("gap%0d_cmdrdy", i), cmd_ready, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
